// File: rtl/aes_pkg.sv
// Shared definitions for the AES-256 key expansion engine.
//   - ks_state_t : controller states
//   - KS_SEL_*   : key-schedule mux select encodings
//   - RCON_INIT, NUM_RK, LAST_GEN_IDX : schedule constants
//   - rot_word, xtime : word rotation and GF(2^8) doubling helpers
package aes_pkg;

  localparam int         NUM_RK    = 15;
  localparam logic [7:0] RCON_INIT = 8'h01;

  // Index of the round key held while the final one (RK14) is generated.
  localparam logic [3:0] LAST_GEN_IDX = 4'(NUM_RK - 2);

  localparam logic [1:0] KS_SEL_MSB    = 2'b00;
  localparam logic [1:0] KS_SEL_LSB    = 2'b01;
  localparam logic [1:0] KS_SEL_FB_MSB = 2'b10;
  localparam logic [1:0] KS_SEL_FB_LSB = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_MSB,
    LOAD_LSB,
    GEN,
    LAST,
    DONE
  } ks_state_t;

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational byte lookup.
// Ports:
//   i_byte [7:0] : input byte
//   o_byte [7:0] : substituted byte
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes256_key_expander.sv
// Sequential AES-256 key expansion engine. Steers the external key-schedule
// mux, loads the two halves of the cipher key, then generates RK2..RK14 one
// per accepted cycle from the two most recent round keys (A older, B newer).
//
// Ports:
//   i_clk, i_rst_n        : clock (rising edge), synchronous active-low reset
//   i_start               : begin expansion, sampled only in IDLE
//   o_ks_sel [1:0]        : mux select, decoded from state
//   i_ks_word [127:0]     : selected mux word, word0 = [127:96]
//   o_fb_msb / o_fb_lsb   : older / newer stored round key (mux feedback)
//   o_round_key [127:0]   : current round key
//   o_rk_index [3:0]      : index 0..14 of o_round_key
//   o_rk_valid / i_rk_ready : output handshake
//   o_busy                : high from LOAD_MSB until DONE exits
//   o_done                : one-cycle pulse after RK14 is accepted
//
// Build option KEYEXP_DEC_KEY_EN adds o_dec_key_msb / o_dec_key_lsb, which
// capture RK13 / RK14 as the decryption starting key pair.
//
// state    | meaning
// ---------+------------------------------------------------------
// IDLE     | waiting for i_start
// LOAD_MSB | mux selects key[255:128]; loads A and RK0
// LOAD_LSB | mux selects key[127:0]; loads B and RK1
// GEN      | derives RK2..RK14 from A/B
// LAST     | RK14 presented, waiting for acceptance
// DONE     | one-cycle done pulse, busy drops on exit
module aes256_key_expander (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  output logic [1:0]   o_ks_sel,
  input  logic [127:0] i_ks_word,
  output logic [127:0] o_fb_msb,
  output logic [127:0] o_fb_lsb,
  output logic [127:0] o_round_key,
  output logic [3:0]   o_rk_index,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic         o_busy,
  output logic         o_done
`ifdef KEYEXP_DEC_KEY_EN
  ,
  output logic [127:0] o_dec_key_msb,
  output logic [127:0] o_dec_key_lsb
`endif
);

  import aes_pkg::*;

  ks_state_t    r_state;
  ks_state_t    w_state_nxt;
  logic [1:0]   w_ks_sel;
  logic         w_adv;

  logic [127:0] r_a;
  logic [127:0] r_b;
  logic [127:0] r_round_key;
  logic [3:0]   r_rk_index;
  logic         r_rk_valid;
  logic         r_busy;
  logic         r_done;
  logic [7:0]   r_rcon;

  logic         w_even;
  logic [31:0]  w_sub_in;
  logic [31:0]  w_sub_out;
  logic [31:0]  w_t;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;
  logic [127:0] w_new_key;

  // The output slot only moves when it is empty or being taken; every
  // register, including the state, is frozen otherwise.
  assign w_adv = !r_rk_valid || i_rk_ready;

  // Next index is even exactly when the current index is odd.
  assign w_even   = r_rk_index[0];
  assign w_sub_in = w_even ? rot_word(r_b[31:0]) : r_b[31:0];

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sub_in[8*g +: 8]),
      .o_byte (w_sub_out[8*g +: 8])
    );
  end

  assign w_t       = w_sub_out ^ (w_even ? {r_rcon, 24'h0} : 32'h0);
  assign w_n0      = r_a[127:96] ^ w_t;
  assign w_n1      = r_a[95:64]  ^ w_n0;
  assign w_n2      = r_a[63:32]  ^ w_n1;
  assign w_n3      = r_a[31:0]   ^ w_n2;
  assign w_new_key = {w_n0, w_n1, w_n2, w_n3};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ks_sel    = KS_SEL_FB_MSB;
    case (r_state)
      IDLE: begin
        if (i_start) w_state_nxt = LOAD_MSB;
      end
      LOAD_MSB: begin
        w_ks_sel = KS_SEL_MSB;
        if (w_adv) w_state_nxt = LOAD_LSB;
      end
      LOAD_LSB: begin
        w_ks_sel = KS_SEL_LSB;
        if (w_adv) w_state_nxt = GEN;
      end
      GEN: begin
        if (w_adv && (r_rk_index == LAST_GEN_IDX)) w_state_nxt = LAST;
      end
      LAST: begin
        if (w_adv) w_state_nxt = DONE;
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_round_key <= '0;
      r_rk_index  <= '0;
      r_rk_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rcon      <= RCON_INIT;
    end else if (w_adv) begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_busy <= 1'b1;
            r_rcon <= RCON_INIT;
          end
        end
        LOAD_MSB: begin
          r_a         <= i_ks_word;
          r_round_key <= i_ks_word;
          r_rk_index  <= 4'd0;
          r_rk_valid  <= 1'b1;
        end
        LOAD_LSB: begin
          r_b         <= i_ks_word;
          r_round_key <= i_ks_word;
          r_rk_index  <= 4'd1;
        end
        GEN: begin
          r_a         <= r_b;
          r_b         <= w_new_key;
          r_round_key <= w_new_key;
          r_rk_index  <= r_rk_index + 4'd1;
          if (w_even) r_rcon <= xtime(r_rcon);
        end
        LAST: begin
          r_rk_valid <= 1'b0;
          r_done     <= 1'b1;
        end
        DONE: begin
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef KEYEXP_DEC_KEY_EN
  logic [127:0] r_dec_key_msb;
  logic [127:0] r_dec_key_lsb;

  // Cleared on a new start so a stale pair is never mistaken for the new key.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_dec_key_msb <= '0;
      r_dec_key_lsb <= '0;
    end else if (w_adv) begin
      if ((r_state == IDLE) && i_start) begin
        r_dec_key_msb <= '0;
        r_dec_key_lsb <= '0;
      end else if (r_state == GEN) begin
        if (r_rk_index == LAST_GEN_IDX - 4'd1) r_dec_key_msb <= w_new_key;
        if (r_rk_index == LAST_GEN_IDX)        r_dec_key_lsb <= w_new_key;
      end
    end
  end

  assign o_dec_key_msb = r_dec_key_msb;
  assign o_dec_key_lsb = r_dec_key_lsb;
`else
  // Encryption-only build: no decryption key pair is kept.
`endif

  assign o_ks_sel    = w_ks_sel;
  assign o_fb_msb    = r_a;
  assign o_fb_lsb    = r_b;
  assign o_round_key = r_round_key;
  assign o_rk_index  = r_rk_index;
  assign o_rk_valid  = r_rk_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
